// File: rtl/mult_hilo_pkg.sv
// Shared encodings for the HI/LO multiplier: operation codes and FSM states.
package mult_hilo_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_MTHI  = 2'b10,
      OP_MTLO  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_FIN  = 2'b10
   } state_e;

endpackage

// File: rtl/mult_hilo_if.sv
// Execute-stage bus between the control unit (master) and the HI/LO multiplier (slave).
interface mult_hilo_if #(parameter int WIDTH = 32);
   import mult_hilo_pkg::*;

   logic             start;
   op_e              op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (output start, op, a, b, input busy, done, hi, lo);
   modport slave  (input start, op, a, b, output busy, done, hi, lo);

endinterface

// File: rtl/mult_core.sv
// Unsigned shift-add datapath: one partial product per step, reports the final step.
// MULT_EARLY_TERM_EN also ends the run once the remaining multiplier bits are all zero.
module mult_core #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               step,
   input  logic [WIDTH-1:0]   mcand_in,
   input  logic [WIDTH-1:0]   mplier_in,
   output logic [2*WIDTH-1:0] acc,
   output logic               last
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
      end else if (load) begin
         mcand  <= {{WIDTH{1'b0}}, mcand_in};
         mplier <= mplier_in;
         acc    <= '0;
         cnt    <= '0;
      end else if (step) begin
         if (mplier[0]) acc <= acc + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
      end
   end

`ifdef MULT_EARLY_TERM_EN
   // Post-shift multiplier is zero when only bit 0 (or nothing) remains.
   assign last = (cnt == CW'(WIDTH-1)) || (mplier[WIDTH-1:1] == '0);
`else
   assign last = (cnt == CW'(WIDTH-1));
`endif

endmodule

// File: rtl/mult_hilo.sv
// Iterative MULT/MULTU with the HI/LO register pair; MTHI/MTLO write in one cycle.
// Build with MULT_EARLY_TERM_EN to shorten runs on small multipliers.
module mult_hilo
   import mult_hilo_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   mult_hilo_if.slave bus
);

   state_e             state, state_nxt;
   logic               load, step, last, neg, is_mul, sgn;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [2*WIDTH-1:0] acc, res;

   assign is_mul = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
   assign sgn    = (bus.op == OP_MULT);
   // Magnitude of the most negative value wraps to itself, which reads correctly as unsigned.
   assign a_mag  = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
   assign b_mag  = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
   assign res    = neg ? -acc : acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      case (state)
         S_IDLE: if (bus.start && is_mul) begin
            load      = 1'b1;
            state_nxt = S_RUN;
         end
         S_RUN: begin
            step = 1'b1;
            if (last) state_nxt = S_FIN;
         end
         S_FIN:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign bus.busy = (state == S_RUN) || (state == S_FIN);

   mult_core #(.WIDTH(WIDTH)) u_core (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .step      (step),
      .mcand_in  (a_mag),
      .mplier_in (b_mag),
      .acc       (acc),
      .last      (last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         neg      <= 1'b0;
         bus.done <= 1'b0;
         bus.hi   <= '0;
         bus.lo   <= '0;
      end else begin
         bus.done <= (state == S_FIN);
         if (load) neg <= sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
         if (state == S_FIN) begin
            bus.hi <= res[2*WIDTH-1:WIDTH];
            bus.lo <= res[WIDTH-1:0];
         end else if (state == S_IDLE && bus.start) begin
            if (bus.op == OP_MTHI) bus.hi <= bus.a;
            if (bus.op == OP_MTLO) bus.lo <= bus.a;
         end
      end
   end

endmodule

// File: tb/tb_mult_hilo.sv
// Directed bench for mult_hilo: signed/unsigned products, MTHI/MTLO, busy-ignore, reset, latency.
module tb_mult_hilo;
   import mult_hilo_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   lat, bcyc;

   mult_hilo_if #(.WIDTH(32)) bus ();

   mult_hilo #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input op_e o, input logic [31:0] x, input logic [31:0] y);
      bus.start = 1'b1;
      bus.op    = o;
      bus.a     = x;
      bus.b     = y;
      tick();
      bus.start = 1'b0;
   endtask

   // Called right after issue(): counts cycles until done and cycles with busy high.
   task automatic wait_done(output int l, output int bc);
      l  = 0;
      bc = 0;
      while (!bus.done && l < 100) begin
         if (bus.busy) bc++;
         tick();
         l++;
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.op    = OP_MULT;
      bus.a     = '0;
      bus.b     = '0;
      tick();
      tick();
      chk("reset_hi", 64'(bus.hi), 64'h0);
      chk("reset_lo", 64'(bus.lo), 64'h0);
      chk("reset_busy_done", 64'({bus.busy, bus.done}), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done(lat, bcyc);
      chk("multu_max_lat", 64'(lat), 64'd33);
      chk("multu_max_busy", 64'(bcyc), 64'd33);
      chk("multu_max", {bus.hi, bus.lo}, 64'hFFFFFFFE_00000001);
      tick();
      chk("done_pulse_end", 64'({bus.busy, bus.done}), 64'h0);

      issue(OP_MULT, 32'hFFFFFFFF, 32'h00000002);
      wait_done(lat, bcyc);
      chk("mult_neg1x2", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFE);

      issue(OP_MULT, 32'h80000000, 32'h80000000);
      wait_done(lat, bcyc);
      chk("mult_minxmin", {bus.hi, bus.lo}, 64'h40000000_00000000);

      issue(OP_MULT, 32'h80000000, 32'h00000001);
      wait_done(lat, bcyc);
      chk("mult_minx1", {bus.hi, bus.lo}, 64'hFFFFFFFF_80000000);

      issue(OP_MULT, 32'hFFFFFFFD, 32'hFFFFFFF9);
      wait_done(lat, bcyc);
      chk("mult_neg3xneg7", {bus.hi, bus.lo}, 64'h00000000_00000015);
      tick();

      issue(OP_MTHI, 32'h12345678, 32'h0);
      chk("mthi_hi", 64'(bus.hi), 64'h12345678);
      chk("mthi_busy_done", 64'({bus.busy, bus.done}), 64'h0);
      issue(OP_MTLO, 32'h9ABCDEF0, 32'h0);
      chk("mtlo_pair", {bus.hi, bus.lo}, 64'h12345678_9ABCDEF0);
      chk("mtlo_busy_done", 64'({bus.busy, bus.done}), 64'h0);

      // MTHI while busy must not touch HI nor start anything.
      issue(OP_MULTU, 32'h00000006, 32'h00000007);
      issue(OP_MTHI, 32'hDEADBEEF, 32'h0);
      chk("busy_mthi_ignored", 64'(bus.hi), 64'h12345678);
      wait_done(lat, bcyc);
      chk("multu_6x7", {bus.hi, bus.lo}, 64'h00000000_0000002A);
      tick();
      tick();
      chk("no_extra_op", 64'({bus.busy, bus.done}), 64'h0);

      issue(OP_MULTU, 32'h00001234, 32'h00005678);
      repeat (9) tick();
      rst_n = 1'b0;
      #1;
      chk("midrun_reset_hilo", {bus.hi, bus.lo}, 64'h0);
      chk("midrun_reset_busy_done", 64'({bus.busy, bus.done}), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      issue(OP_MULTU, 32'd3, 32'd5);
      wait_done(lat, bcyc);
      chk("post_reset_3x5", {bus.hi, bus.lo}, 64'h00000000_0000000F);

`ifdef MULT_EARLY_TERM_EN
      issue(OP_MULTU, 32'd7, 32'd1);
      wait_done(lat, bcyc);
      chk("et_7x1_lat", 64'(lat), 64'd2);
      chk("et_7x1", {bus.hi, bus.lo}, 64'h00000000_00000007);
      issue(OP_MULTU, 32'h0000ABCD, 32'd0);
      wait_done(lat, bcyc);
      chk("et_bzero_lat", 64'(lat), 64'd2);
      chk("et_bzero", {bus.hi, bus.lo}, 64'h0);
      issue(OP_MULTU, 32'd3, 32'h80000000);
      wait_done(lat, bcyc);
      chk("et_bmsb_lat", 64'(lat), 64'd33);
      chk("et_bmsb", {bus.hi, bus.lo}, 64'h00000001_80000000);
`else
      issue(OP_MULTU, 32'd7, 32'd1);
      wait_done(lat, bcyc);
      chk("fixed_7x1_lat", 64'(lat), 64'd33);
      chk("fixed_7x1", {bus.hi, bus.lo}, 64'h00000000_00000007);
      issue(OP_MULTU, 32'h0000ABCD, 32'd0);
      wait_done(lat, bcyc);
      chk("fixed_bzero_busy", 64'(bcyc), 64'd33);
      chk("fixed_bzero", {bus.hi, bus.lo}, 64'h0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
